// File: rtl/intmul_rr_sched.sv
// intmul_rr_sched
//   Round-robin scheduler that shares one fully pipelined integer multiplier
//   (latency LAT, instantiated outside) between NREQ requesters. At most one
//   A*B is issued per cycle. Each issue is tagged with its requester ID, and the
//   product comes back with that ID exactly LAT cycles later.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   en         issue enable; 0 blocks all grants while in-flight ops drain
//   req_valid  per-requester operand valid
//   req_a      operand A, requester i at [i*LOGA +: LOGA]
//   req_b      operand B, requester i at [i*LOGB +: LOGB]
//   req_ready  one-hot grant; handshake on req_valid[i] & req_ready[i]
//   mul_A      operand A to the multiplier (0 when idle)
//   mul_B      operand B to the multiplier (0 when idle)
//   mul_C      product from the multiplier
//   rsp_valid  single-cycle product valid, no backpressure
//   rsp_id     requester that owns rsp_c
//   rsp_c      product, passed straight through from mul_C
//   inflight   number of issued but not yet returned operations, 0..LAT
//   busy       inflight != 0
module intmul_rr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LOGA = 64,
  parameter int unsigned LOGB = 64,
  parameter int unsigned LAT  = 3,
  localparam int unsigned IDW = $clog2(NREQ),
  localparam int unsigned ICW = $clog2(LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*LOGA-1:0]   req_a,
  input  logic [NREQ*LOGB-1:0]   req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [LOGA-1:0]        mul_A,
  output logic [LOGB-1:0]        mul_B,
  input  logic [LOGA+LOGB-1:0]   mul_C,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [LOGA+LOGB-1:0]   rsp_c,
  output logic [ICW-1:0]         inflight,
  output logic                   busy
);

  logic [IDW-1:0] r_ptr;
  logic [LAT-1:0] r_tag_v;
  logic [IDW-1:0] r_tag_id [LAT];
  logic [ICW-1:0] r_inflight;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic           w_issue;
  logic           w_retire;
  logic [IDW-1:0] w_ptr_next;

  // Scan ptr, ptr+1, ... with wrap; the first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW + 1)'(k);
      if (w_sum >= (IDW + 1)'(NREQ)) begin
        w_sum = w_sum - (IDW + 1)'(NREQ);
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_issue  = w_found & en & ~rst;
  assign w_retire = r_tag_v[LAT-1];

  always_comb begin
    req_ready = '0;
    mul_A     = '0;
    mul_B     = '0;
    if (w_issue) begin
      req_ready[w_win] = 1'b1;
      mul_A            = req_a[w_win*LOGA +: LOGA];
      mul_B            = req_b[w_win*LOGB +: LOGB];
    end
  end

  assign w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= w_ptr_next;
    end
  end

  // {valid,id} tag pipeline, aligned with the external multiplier latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      for (int unsigned s = LAT - 1; s > 0; s--) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_issue ? w_win : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      case ({w_issue, w_retire})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign rsp_valid = w_retire;
  assign rsp_id    = r_tag_id[LAT-1];
  assign rsp_c     = mul_C;
  assign inflight  = r_inflight;
  assign busy      = (r_inflight != '0);

  // Issue count can never outrun the pipeline depth, and a retire always has a matching issue.
  a_inflight_max : assert property (@(posedge clk) disable iff (rst)
    r_inflight <= ICW'(LAT));
  a_inflight_min : assert property (@(posedge clk) disable iff (rst)
    !(w_retire && !w_issue && r_inflight == '0));

endmodule

// File: tb/tb_intmul_rr_sched.sv
// Randomized + directed bench for intmul_rr_sched with a behavioural multiplier,
// a scoreboard of expected {id, product} and a separate response monitor.
module tb_intmul_rr_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LOGA = 64;
  localparam int unsigned LOGB = 64;
  localparam int unsigned LAT  = 3;
  localparam int unsigned IDW  = 2;
  localparam int unsigned ICW  = 2;
  localparam int unsigned CW   = LOGA + LOGB;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*LOGA-1:0] req_a;
  logic [NREQ*LOGB-1:0] req_b;
  logic [NREQ-1:0]      req_ready;
  logic [LOGA-1:0]      mul_A;
  logic [LOGB-1:0]      mul_B;
  logic [CW-1:0]        mul_C;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [CW-1:0]        rsp_c;
  logic [ICW-1:0]       inflight;
  logic                 busy;

  intmul_rr_sched #(
    .NREQ(NREQ),
    .LOGA(LOGA),
    .LOGB(LOGB),
    .LAT (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .mul_A    (mul_A),
    .mul_B    (mul_B),
    .mul_C    (mul_C),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_c    (rsp_c),
    .inflight (inflight),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multiplier of latency LAT.
  logic [CW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    for (int s = LAT - 1; s > 0; s--) mpipe[s] <= mpipe[s-1];
    mpipe[0] <= CW'(mul_A) * CW'(mul_B);
  end
  assign mul_C = mpipe[LAT-1];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [CW-1:0]  c;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   mon_en = 1'b0;

  int   ref_ptr = 0;
  bit   hist[$];

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding issue.
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en && rsp_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected at %0t: got rsp_valid=%b id=%0d, expected no response",
                 $time, rsp_valid, rsp_id);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_valid", CW'(rsp_valid), CW'(1));
        chk("rsp_id", CW'(rsp_id), CW'(mon_e.id));
        chk("rsp_c", rsp_c, mon_e.c);
      end
    end
  end

  task automatic set_req(input int i, input bit v, input logic [LOGA-1:0] a,
                         input logic [LOGB-1:0] b);
    req_valid[i]            = v;
    req_a[i*LOGA +: LOGA]   = a;
    req_b[i*LOGB +: LOGB]   = b;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  // One clock cycle: check combinational outputs against the reference, log the issue,
  // then advance the reference across the edge.
  task automatic step();
    bit              found;
    int              w;
    int              idx;
    bit              issue;
    int              exp_inf;
    logic [NREQ-1:0] exp_ready;
    logic [LOGA-1:0] ea;
    logic [LOGB-1:0] eb;
    exp_t            e;
    @(negedge clk);
    found = 1'b0;
    w     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ref_ptr + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        w     = idx;
      end
    end
    issue     = found && en && !rst;
    exp_ready = '0;
    ea        = '0;
    eb        = '0;
    if (issue) begin
      exp_ready[w] = 1'b1;
      ea           = req_a[w*LOGA +: LOGA];
      eb           = req_b[w*LOGB +: LOGB];
    end
    exp_inf = 0;
    foreach (hist[j]) exp_inf += int'(hist[j]);
    chk("req_ready", CW'(req_ready), CW'(exp_ready));
    chk("mul_A", CW'(mul_A), CW'(ea));
    chk("mul_B", CW'(mul_B), CW'(eb));
    chk("inflight", CW'(inflight), CW'(exp_inf));
    chk("busy", CW'(busy), CW'(exp_inf != 0));
    if (issue) begin
      e.id = IDW'(w);
      e.c  = CW'(ea) * CW'(eb);
      sb.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      ref_ptr = 0;
      sb.delete();
      hist.delete();
      for (int j = 0; j < LAT; j++) hist.push_back(1'b0);
    end else begin
      if (issue) ref_ptr = (w + 1) % NREQ;
      hist.push_back(issue);
      void'(hist.pop_front());
    end
    #1;
  endtask

  initial begin
    for (int j = 0; j < LAT; j++) hist.push_back(1'b0);
    rst = 1'b1;
    en  = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    mon_en = 1'b1;
    chk("reset_rsp_valid", CW'(rsp_valid), CW'(0));
    chk("reset_rsp_id", CW'(rsp_id), CW'(0));
    chk("reset_busy", CW'(busy), CW'(0));
    chk("reset_inflight", CW'(inflight), CW'(0));
    chk("reset_req_ready", CW'(req_ready), CW'(0));

    // Single request on req1: 7*9.
    set_req(1, 1'b1, 64'd7, 64'd9);
    step();
    clear_reqs();
    repeat (LAT + 1) step();

    // Full contention for 8 cycles from a fresh pointer.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (8) step();
    clear_reqs();
    repeat (LAT + 1) step();

    // Pointer wrap: req2 alone moves ptr to 3, then req0 and req2 compete.
    set_req(2, 1'b1, 64'd11, 64'd13);
    step();
    set_req(0, 1'b1, 64'd5, 64'd6);
    repeat (2) step();
    clear_reqs();
    repeat (LAT + 1) step();

    // Drain mode after two issues.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (2) step();
    en = 1'b0;
    repeat (6) step();
    en = 1'b1;
    clear_reqs();

    // Reset one cycle after three back-to-back issues.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (3) step();
    clear_reqs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (LAT + 2) step();
    set_req(3, 1'b1, 64'd3, 64'd4);
    set_req(2, 1'b1, 64'd8, 64'd2);
    step();
    clear_reqs();
    repeat (LAT + 1) step();

    // Maximum operands on req3.
    set_req(3, 1'b1, '1, '1);
    step();
    clear_reqs();
    repeat (LAT + 1) step();

    // Random traffic with occasional drain and reset.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      end
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    en  = 1'b0;
    clear_reqs();
    repeat (LAT + 2) step();
    chk("sb_empty", CW'(sb.size()), CW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
